// File: rtl/otter_rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package otter_rf_pkg;

   localparam int XLEN      = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_DEPTH  = 32;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [XLEN-1:0]      rf_data_t;

   // One writeback request as it travels toward the register file
   typedef struct packed {
      rf_addr_t addr;
      rf_data_t data;
   } wb_req_t;

endpackage

// File: rtl/otter_rr_arbiter.sv
// Generic round-robin arbiter. The search for a grant starts at the
// pointer and wraps; the pointer moves past the winner only when the
// caller reports that the grant was actually taken (i_advance).
module otter_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_advance,
   output logic [NUM_REQ-1:0] o_grant
);
   import otter_rf_pkg::*;

   localparam int             PTR_W     = $clog2(NUM_REQ);
   localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;
   logic [PTR_W-1:0] winner;
   logic             found;
   logic [PTR_W:0]   idx;

   // Rotating priority search: first requester at or after the pointer wins
   always_comb begin
      o_grant = '0;
      winner  = '0;
      found   = 1'b0;
      idx     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = {1'b0, ptr_reg} + (PTR_W+1)'(off);
         if (idx >= NUM_REQ_W) begin
            idx = idx - NUM_REQ_W;
         end
         if (!found && i_req[idx[PTR_W-1:0]]) begin
            found                  = 1'b1;
            winner                 = idx[PTR_W-1:0];
            o_grant[idx[PTR_W-1:0]] = 1'b1;
         end
      end
   end

   // Pointer moves to the requester after the winner, only on an accepted grant
   always_comb begin
      ptr_next = ptr_reg;
      if (i_advance && found) begin
         ptr_next = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);
      end
   end

   // Pointer state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/otter_rf_wb_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Several writeback sources share the single rfile write port; the
// winner is registered onto o_w_*. The scoreboard tracks registers
// reserved by long-latency ops so reads can be stalled on hazards.
// Optional build macro OTTER_RF_BYPASS_EN: exposes the in-flight write
// as forwarding data instead of reporting it as a hazard.
// XLEN/RF_ADDR_W must match the constants in otter_rf_pkg.
module otter_rf_wb_arbiter #(
   parameter int NUM_REQ   = 2,
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   input  logic [NUM_REQ*RF_ADDR_W-1:0] i_req_addr,
   input  logic [NUM_REQ*XLEN-1:0]      i_req_data,
   input  logic                         i_rsv_en,
   input  logic [RF_ADDR_W-1:0]         i_rsv_addr,
   input  logic [RF_ADDR_W-1:0]         i_r_addr1,
   input  logic [RF_ADDR_W-1:0]         i_r_addr2,
   output logic                         o_w_en,
   output logic [RF_ADDR_W-1:0]         o_w_addr,
   output logic [XLEN-1:0]              o_w_data,
   output logic                         o_hazard1,
   output logic                         o_hazard2
`ifdef OTTER_RF_BYPASS_EN
   ,
   output logic                         o_fwd_valid1,
   output logic                         o_fwd_valid2,
   output logic [XLEN-1:0]              o_fwd_data1,
   output logic [XLEN-1:0]              o_fwd_data2
`endif
);
   import otter_rf_pkg::*;

   logic [NUM_REQ-1:0]  grant;
   logic                accept;
   wb_req_t             sel_req;
   logic                w_en_reg;
   rf_addr_t            w_addr_reg;
   rf_data_t            w_data_reg;
   logic [RF_DEPTH-1:0] pending_reg;
   logic [RF_DEPTH-1:0] pending_next;
   logic                pend1, pend2;
   logic                inflight1, inflight2;
   logic                nz1, nz2;

   // The rfile never stalls, so ready is just the grant (masked in reset)
   assign o_req_ready = i_rst ? '0 : grant;
   assign accept      = |(i_req_valid & o_req_ready);

   otter_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (i_req_valid),
      .i_advance (accept),
      .o_grant   (grant)
   );

   // Select the granted requester's address and data
   always_comb begin
      sel_req = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_req.addr = i_req_addr[k*RF_ADDR_W +: RF_ADDR_W];
            sel_req.data = i_req_data[k*XLEN +: XLEN];
         end
      end
   end

   // Output register: x0 writes are consumed but never raise the write enable
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         w_en_reg   <= 1'b0;
         w_addr_reg <= '0;
         w_data_reg <= '0;
      end else if (accept) begin
         w_en_reg   <= (sel_req.addr != '0);
         w_addr_reg <= sel_req.addr;
         w_data_reg <= sel_req.data;
      end else begin
         w_en_reg   <= 1'b0;
      end
   end

   assign o_w_en   = w_en_reg;
   assign o_w_addr = w_addr_reg;
   assign o_w_data = w_data_reg;

   // Scoreboard next state; a same-cycle reservation beats the clearing write
   assign pending_next[0] = 1'b0;
   for (genvar gi = 1; gi < RF_DEPTH; gi++) begin : g_pending
      logic set_bit;
      logic clr_bit;
      assign set_bit = i_rsv_en & (i_rsv_addr == rf_addr_t'(gi));
      assign clr_bit = accept & (sel_req.addr == rf_addr_t'(gi));
      assign pending_next[gi] = set_bit | (pending_reg[gi] & ~clr_bit);
   end

   // Scoreboard state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   assign nz1       = (i_r_addr1 != '0);
   assign nz2       = (i_r_addr2 != '0);
   assign pend1     = pending_reg[i_r_addr1];
   assign pend2     = pending_reg[i_r_addr2];
   assign inflight1 = w_en_reg & (w_addr_reg == i_r_addr1);
   assign inflight2 = w_en_reg & (w_addr_reg == i_r_addr2);

`ifdef OTTER_RF_BYPASS_EN
   // The in-flight write is forwarded, so only reserved registers stall
   assign o_hazard1    = nz1 & pend1;
   assign o_hazard2    = nz2 & pend2;
   assign o_fwd_valid1 = nz1 & inflight1;
   assign o_fwd_valid2 = nz2 & inflight2;
   assign o_fwd_data1  = w_data_reg;
   assign o_fwd_data2  = w_data_reg;
`else
   // Without forwarding, a read of the register being written must wait
   assign o_hazard1 = nz1 & (pend1 | inflight1);
   assign o_hazard2 = nz2 & (pend2 | inflight2);
`endif

endmodule

// File: tb/tb_otter_rf_wb_arbiter.sv
// Self-checking bench for otter_rf_wb_arbiter (either OTTER_RF_BYPASS_EN build).
module tb_otter_rf_wb_arbiter;

   localparam int N = 2;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_addr;
   logic [63:0] req_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [4:0]  r_addr1, r_addr2;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        hazard1, hazard2;
`ifdef OTTER_RF_BYPASS_EN
   logic        fwd_valid1, fwd_valid2;
   logic [31:0] fwd_data1, fwd_data2;
`endif

   int          errors = 0;
   int          checks = 0;

   // Bench-side reference state
   int          exp_ptr;
   logic [31:0] exp_pending;
   logic        exp_w_en;
   logic [4:0]  exp_w_addr;
   logic [31:0] exp_w_data;
   wr_t         exp_q[$];
   logic [31:0] rf_model[32];

   always #5 clk = ~clk;

   otter_rf_wb_arbiter #(.NUM_REQ(N), .XLEN(32), .RF_ADDR_W(5)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_addr  (req_addr),
      .i_req_data  (req_data),
      .i_rsv_en    (rsv_en),
      .i_rsv_addr  (rsv_addr),
      .i_r_addr1   (r_addr1),
      .i_r_addr2   (r_addr2),
      .o_w_en      (w_en),
      .o_w_addr    (w_addr),
      .o_w_data    (w_data),
      .o_hazard1   (hazard1),
      .o_hazard2   (hazard2)
`ifdef OTTER_RF_BYPASS_EN
      ,
      .o_fwd_valid1 (fwd_valid1),
      .o_fwd_valid2 (fwd_valid2),
      .o_fwd_data1  (fwd_data1),
      .o_fwd_data2  (fwd_data2)
`endif
   );

   function automatic logic [1:0] model_grant(input logic [1:0] v, input int ptr);
      logic [1:0] g;
      logic       hit;
      g   = '0;
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (ptr + k) % N;
         if (!hit && v[idx]) begin
            g[idx] = 1'b1;
            hit    = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic model_hazard(input logic [4:0] r);
`ifdef OTTER_RF_BYPASS_EN
      return (r != 0) && exp_pending[r];
`else
      return (r != 0) && (exp_pending[r] || (exp_w_en && exp_w_addr == r));
`endif
   endfunction

   function automatic logic model_fwd(input logic [4:0] r);
      return (r != 0) && exp_w_en && (exp_w_addr == r);
   endfunction

   task automatic idle_inputs();
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      rsv_en    = 1'b0;
      rsv_addr  = '0;
      r_addr1   = '0;
      r_addr2   = '0;
   endtask

   task automatic model_reset();
      exp_ptr     = 0;
      exp_pending = '0;
      exp_w_en    = 1'b0;
      exp_w_addr  = '0;
      exp_w_data  = '0;
      exp_q.delete();
   endtask

   // One clock: commit the current rfile write into the bench rfile, then
   // advance the reference model with the inputs seen at the edge and push
   // the expected output-register contents.
   task automatic tick();
      logic [1:0] g;
      wr_t        e;
      if (w_en) rf_model[w_addr] = w_data;
      g = model_grant(req_valid, exp_ptr);
      @(posedge clk);
      e.en   = 1'b0;
      e.addr = exp_w_addr;
      e.data = exp_w_data;
      for (int k = 0; k < N; k++) begin
         if (g[k]) begin
            e.addr  = req_addr[k*5 +: 5];
            e.data  = req_data[k*32 +: 32];
            e.en    = (e.addr != 0);
            exp_ptr = (k + 1) % N;
            if (e.addr != 0) exp_pending[e.addr] = 1'b0;
         end
      end
      if (rsv_en && rsv_addr != 0) exp_pending[rsv_addr] = 1'b1;
      exp_w_en   = e.en;
      exp_w_addr = e.addr;
      exp_w_data = e.data;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      wr_t e;
      idle_inputs();
      req_valid = 2'b11;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready: got %b want 00", req_ready);
      end
      checks++;
      if (w_en !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_out: got en=%b addr=%0d data=%h want 0/0/0", w_en, w_addr, w_data);
      end
      rst = 1'b0;
      model_reset();
      // Put a write in flight and reserve x5, then reset mid-cycle
      idle_inputs();
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'd7};
      req_data  = {32'd0, 32'h11111111};
      rsv_en    = 1'b1;
      rsv_addr  = 5'd5;
      #1;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (w_en !== e.en || w_addr !== e.addr || w_data !== e.data) begin
         errors++;
         $display("FAIL reset_prewrite: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                  w_en, w_addr, w_data, e.en, e.addr, e.data);
      end
      #2;
      rst = 1'b1;
      idle_inputs();
      r_addr1 = 5'd5;
      #1;
      checks++;
      if (w_en !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_async: got en=%b addr=%0d data=%h want 0/0/0", w_en, w_addr, w_data);
      end
      rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (hazard1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_pending: hazard1 got %b want 0", hazard1);
      end
   endtask

   task automatic test_single();
      wr_t e;
      idle_inputs();
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'd1};
      req_data  = {32'd0, 32'hDEADBEEF};
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL single_ready: got %b want 01", req_ready);
      end
      tick();
      idle_inputs();
      e = exp_q.pop_front();
      checks++;
      if (w_en !== 1'b1 || w_addr !== 5'd1 || w_data !== 32'hDEADBEEF || e.data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_out: got en=%b addr=%0d data=%h want 1/1/deadbeef", w_en, w_addr, w_data);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (w_en !== e.en || w_addr !== e.addr || w_data !== e.data) begin
         errors++;
         $display("FAIL single_idle: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                  w_en, w_addr, w_data, e.en, e.addr, e.data);
      end
      checks++;
      if (rf_model[1] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_rfile: reg1 got %h want deadbeef", rf_model[1]);
      end
   endtask

   task automatic test_contention();
      wr_t        e;
      logic [1:0] g;
      int         cnt0 = 0;
      int         cnt1 = 0;
      idle_inputs();
      req_valid = 2'b11;
      req_addr  = {5'd10, 5'd5};
      req_data  = {32'h87654321, 32'h12345678};
      for (int c = 0; c < 8; c++) begin
         #1;
         g = model_grant(req_valid, exp_ptr);
         checks++;
         if (req_ready !== g) begin
            errors++;
            $display("FAIL contention_ready[%0d]: got %b want %b", c, req_ready, g);
         end
         if (req_ready[0]) cnt0++;
         if (req_ready[1]) cnt1++;
         tick();
         e = exp_q.pop_front();
         checks++;
         if (w_en !== e.en || w_addr !== e.addr || w_data !== e.data) begin
            errors++;
            $display("FAIL contention_out[%0d]: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                     c, w_en, w_addr, w_data, e.en, e.addr, e.data);
         end
      end
      checks++;
      if (cnt0 != 4 || cnt1 != 4) begin
         errors++;
         $display("FAIL contention_share: got %0d/%0d grants want 4/4", cnt0, cnt1);
      end
   endtask

   task automatic test_x0();
      wr_t e;
      idle_inputs();
      req_valid = 2'b10;
      req_addr  = {5'd0, 5'd0};
      req_data  = {32'hFFFFFFFF, 32'd0};
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL x0_ready: got %b want 10", req_ready);
      end
      tick();
      idle_inputs();
      e = exp_q.pop_front();
      checks++;
      if (w_en !== 1'b0 || w_addr !== e.addr || w_data !== e.data) begin
         errors++;
         $display("FAIL x0_out: got en=%b addr=%0d data=%h want en=0 addr=%0d data=%h",
                  w_en, w_addr, w_data, e.addr, e.data);
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rf_model[0] !== 32'd0 || w_en !== e.en) begin
         errors++;
         $display("FAIL x0_rfile: reg0 got %h en=%b want 0 en=%b", rf_model[0], w_en, e.en);
      end
   endtask

   task automatic test_scoreboard();
      wr_t e;
      idle_inputs();
      rsv_en   = 1'b1;
      rsv_addr = 5'd15;
      r_addr1  = 5'd15;
      #1;
      checks++;
      if (hazard1 !== 1'b0) begin
         errors++;
         $display("FAIL sb_before_rsv: hazard1 got %b want 0", hazard1);
      end
      tick();
      void'(exp_q.pop_front());
      rsv_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_hold[%0d]: hazard1 got %b want 1", c, hazard1);
         end
         tick();
         void'(exp_q.pop_front());
      end
      req_valid = 2'b10;
      req_addr  = {5'd15, 5'd0};
      req_data  = {32'hCAFEBABE, 32'd0};
      #1;
      tick();
      req_valid = 2'b00;
      e = exp_q.pop_front();
      checks++;
      if (w_en !== 1'b1 || w_addr !== 5'd15 || w_data !== 32'hCAFEBABE || e.addr !== 5'd15) begin
         errors++;
         $display("FAIL sb_write: got en=%b addr=%0d data=%h want 1/15/cafebabe", w_en, w_addr, w_data);
      end
      checks++;
      if (hazard1 !== model_hazard(5'd15)) begin
         errors++;
         $display("FAIL sb_inflight: hazard1 got %b want %b", hazard1, model_hazard(5'd15));
      end
      tick();
      void'(exp_q.pop_front());
      checks++;
      if (hazard1 !== 1'b0) begin
         errors++;
         $display("FAIL sb_cleared: hazard1 got %b want 0", hazard1);
      end
      // Reservation and write of x16 in the same cycle: reservation wins
      rsv_en    = 1'b1;
      rsv_addr  = 5'd16;
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'd16};
      req_data  = {32'd0, 32'h16161616};
      r_addr2   = 5'd16;
      #1;
      tick();
      void'(exp_q.pop_front());
      rsv_en    = 1'b0;
      req_valid = 2'b00;
      #1;
      checks++;
      if (hazard2 !== 1'b1) begin
         errors++;
         $display("FAIL sb_setwins_a: hazard2 got %b want 1", hazard2);
      end
      tick();
      void'(exp_q.pop_front());
      checks++;
      if (hazard2 !== 1'b1 || exp_pending[16] !== 1'b1) begin
         errors++;
         $display("FAIL sb_setwins_b: hazard2 got %b want 1", hazard2);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      req_valid = 2'b01;
      req_addr  = {5'd0, 5'd3};
      req_data  = {32'd0, 32'hABCDEF00};
      r_addr2   = 5'd3;
      #1;
      tick();
      void'(exp_q.pop_front());
      req_valid = 2'b00;
      #1;
`ifdef OTTER_RF_BYPASS_EN
      checks++;
      if (fwd_valid2 !== 1'b1 || fwd_data2 !== 32'hABCDEF00 || hazard2 !== 1'b0) begin
         errors++;
         $display("FAIL bypass_fwd: got v=%b d=%h hz=%b want 1/abcdef00/0", fwd_valid2, fwd_data2, hazard2);
      end
`else
      checks++;
      if (hazard2 !== 1'b1) begin
         errors++;
         $display("FAIL bypass_hazard: hazard2 got %b want 1", hazard2);
      end
`endif
      tick();
      void'(exp_q.pop_front());
      checks++;
      if (hazard2 !== 1'b0) begin
         errors++;
         $display("FAIL bypass_after: hazard2 got %b want 0", hazard2);
      end
   endtask

   task automatic test_back_to_back();
      wr_t        e;
      logic [1:0] g;
      for (int c = 0; c < 40; c++) begin
         req_valid = 2'($urandom_range(0, 3));
         req_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         req_data  = {$urandom, $urandom};
         rsv_en    = 1'($urandom_range(0, 1));
         rsv_addr  = 5'($urandom_range(0, 7));
         r_addr1   = 5'($urandom_range(0, 7));
         r_addr2   = 5'($urandom_range(0, 7));
         #1;
         g = model_grant(req_valid, exp_ptr);
         checks++;
         if (req_ready !== g || hazard1 !== model_hazard(r_addr1) || hazard2 !== model_hazard(r_addr2)) begin
            errors++;
            $display("FAIL b2b_comb[%0d]: got rdy=%b hz=%b%b want rdy=%b hz=%b%b", c, req_ready,
                     hazard1, hazard2, g, model_hazard(r_addr1), model_hazard(r_addr2));
         end
`ifdef OTTER_RF_BYPASS_EN
         checks++;
         if (fwd_valid1 !== model_fwd(r_addr1) || fwd_valid2 !== model_fwd(r_addr2) ||
             fwd_data1 !== exp_w_data || fwd_data2 !== exp_w_data) begin
            errors++;
            $display("FAIL b2b_fwd[%0d]: got v=%b%b want v=%b%b", c, fwd_valid1, fwd_valid2,
                     model_fwd(r_addr1), model_fwd(r_addr2));
         end
`endif
         tick();
         e = exp_q.pop_front();
         checks++;
         if (w_en !== e.en || w_addr !== e.addr || w_data !== e.data) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h",
                     c, w_en, w_addr, w_data, e.en, e.addr, e.data);
         end
      end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = '0;
      model_reset();
      test_reset();
      test_single();
      test_contention();
      test_x0();
      test_scoreboard();
      test_bypass();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/otter_rf_wb_arbiter.md
Name: otter_rf_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters, e.g. the pipeline writeback and a long-latency load/mul-div unit. Requests use a valid/ready handshake and are granted round-robin. The winning request is registered and driven onto otter_rfile's i_w_en/i_w_addr/i_w_data. A 32-entry pending-write scoreboard flags read-after-write hazards on both read addresses, so the pipeline can stall.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4)
XLEN, 32, data width
RF_ADDR_W, 5, register address width (32 registers)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  NUM_REQ  per-requester write valid
o_req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
i_req_addr  in  NUM_REQ*RF_ADDR_W  packed destination addresses, requester k at [k*5 +: 5]
i_req_data  in  NUM_REQ*XLEN  packed write data
i_rsv_en  in  1  reserve destination of a newly issued long-latency op
i_rsv_addr  in  RF_ADDR_W  register to reserve
i_r_addr1  in  RF_ADDR_W  read address 1 (same net as rfile i_r_addr1)
i_r_addr2  in  RF_ADDR_W  read address 2
o_w_en  out  1  to rfile i_w_en
o_w_addr  out  RF_ADDR_W  to rfile i_w_addr
o_w_data  out  XLEN  to rfile i_w_data
o_hazard1  out  1  read 1 targets a pending or in-flight write
o_hazard2  out  1  read 2 targets a pending or in-flight write

Behaviour:
- Reset (async, i_rst=1):
  - o_w_en=0, o_w_addr=0, o_w_data=0.
  - Pending vector = 0; round-robin pointer = 0.
  - o_req_ready = 0 while reset is held.
  - Any in-flight write is dropped, not retried.
- Grant (combinational):
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - The first requester with valid=1 gets ready=1. Only that one.
  - Ready does not depend on any downstream backpressure; the rfile always accepts.
- Accept = valid & ready at a rising edge.
  - On accept, the pointer moves to (winner+1) mod NUM_REQ.
  - With no accept, the pointer holds.
- Output register:
  - On accept: o_w_en <= (addr != 0), o_w_addr <= addr, o_w_data <= data.
  - With no accept: o_w_en <= 0; addr/data hold their last value.
- Latency: accept at edge N -> o_w_en high during cycle N..N+1 -> rfile commits at edge N+1. One write per cycle sustained.
- Writes to x0 are consumed (ready=1) but never drive o_w_en.
- Scoreboard pending[31:0], bit 0 is constant 0:
  - i_rsv_en with addr != 0 sets the bit at the next edge.
  - An accepted write with addr != 0 clears the bit at the next edge.
  - Set and clear of the same address in the same cycle: set wins (new reservation supersedes).
  - Reserving an already-pending register keeps it set.
  - A write to a non-pending register is legal and leaves the bit clear.
- Hazards (combinational):
  - o_hazardN = (rN != 0) & (pending[rN] | (o_w_en & o_w_addr == rN)).
  - Address 0 never hazards.

Optional Feature:
- Macro: OTTER_RF_BYPASS_EN.
- Defined: adds ports o_fwd_valid1, o_fwd_valid2 (1 bit each) and o_fwd_data1, o_fwd_data2 (XLEN each).
  - o_fwd_validN = o_w_en & (o_w_addr == rN) & (rN != 0); o_fwd_dataN = o_w_data.
  - The in-flight term is removed from o_hazardN; only pending[rN] hazards.
- Undefined: no forwarding ports; the in-flight write counts as a hazard, as above.

Decomposition:
- Package otter_rf_pkg:
  - constants XLEN, RF_ADDR_W, RF_DEPTH=32
  - typedefs rf_addr_t, rf_data_t
  - struct wb_req_t {addr, data}
- Sub-module otter_rr_arbiter: generic NUM_REQ round-robin, inputs req/advance, output one-hot grant, owns the pointer.
- The scoreboard and output register stay in the top module.

Test Plan:
- Reset check: assert i_rst mid-write (o_w_en=1) -> outputs go to 0 immediately; pending=0; after release, r_addr1=5 gives o_hazard1=0.
- Single request: req0 valid, addr=1, data=DEADBEEF -> ready0=1; next cycle o_w_en=1, o_w_addr=1, o_w_data=DEADBEEF; rfile reads 1 -> DEADBEEF one cycle later.
- Contention, both valid continuously (req0 addr 5 data 12345678, req1 addr 10 data 87654321) -> grants alternate 0,1,0,1; each requester gets exactly 50% over 8 cycles.
- x0 write: req1 addr=0, data=FFFFFFFF -> ready1=1, o_w_en stays 0, rfile reg0 reads 0.
- Scoreboard:
  - rsv_en addr=15 -> o_hazard1=1 for r_addr1=15 until req1 writes CAFEBABE; hazard drops the cycle after commit.
  - rsv addr 16 and accept addr 16 in the same cycle -> pending[16] stays 1.
- Bypass, with OTTER_RF_BYPASS_EN: accept addr=3 data=ABCDEF00, r_addr2=3 -> o_fwd_valid2=1, o_fwd_data2=ABCDEF00, o_hazard2=0. Without the macro -> o_hazard2=1 for that cycle.
